// File: rtl/find_best_hop_pkg.sv
// Shared constants and state encoding for the neighbour-table scanner
// and its downstream consumer selectMyAction.
package find_best_hop_pkg;

  localparam int unsigned MEM_DEPTH  = 65536;
  localparam int unsigned MEM_WIDTH  = 8;
  localparam int unsigned WORD_WIDTH = 16;

  localparam logic [15:0] NONE_ID      = 16'd65;
  localparam int unsigned MAX_NBR      = 64;
  localparam logic [15:0] CNT_ADDR     = 16'h0010;
  localparam logic [15:0] NBR_BASE     = 16'h0020;
  localparam logic [15:0] ENTRY_STRIDE = 16'd8;

  localparam logic [15:0] OFF_ID = 16'd0;
  localparam logic [15:0] OFF_CL = 16'd2;
  localparam logic [15:0] OFF_FL = 16'd4;
  localparam logic [15:0] OFF_Q  = 16'd6;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CNT_REQ = 4'd1,
    S_CNT_CAP = 4'd2,
    S_ID_REQ  = 4'd3,
    S_CL_REQ  = 4'd4,
    S_FL_REQ  = 4'd5,
    S_Q_REQ   = 4'd6,
    S_EVAL    = 4'd7,
    S_DONE    = 4'd8
  } state_e;

  function automatic logic [15:0] entry_addr(
    input logic [6:0]  idx,
    input logic [15:0] off
  );
    return NBR_BASE + 16'(idx) * ENTRY_STRIDE + off;
  endfunction

endpackage

// File: rtl/find_best_hop_best_tracker.sv
// Holds one best-so-far candidate; strict > keeps the earliest on ties.
module best_tracker
  import find_best_hop_pkg::*;
(
  input  logic        clock,
  input  logic        nrst,
  input  logic        clear_i,
  input  logic        qualify_i,
  input  logic        update_i,
  input  logic [15:0] id_i,
  input  logic [15:0] q_i,
  output logic [15:0] id_o
);

  logic [15:0] id_q, id_d;
  logic [15:0] q_q, q_d;
  logic        have_q, have_d;
  logic        take;

  assign take = update_i && qualify_i
             && (!have_q || (q_i > q_q));

  always_comb begin
    id_d   = id_q;
    q_d    = q_q;
    have_d = have_q;
    if (clear_i) begin
      id_d   = NONE_ID;
      q_d    = '0;
      have_d = 1'b0;
    end else if (take) begin
      id_d   = id_i;
      q_d    = q_i;
      have_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      id_q   <= NONE_ID;
      q_q    <= '0;
      have_q <= 1'b0;
    end else begin
      id_q   <= id_d;
      q_q    <= q_d;
      have_q <= have_d;
    end
  end

  assign id_o = id_q;

endmodule

// File: rtl/find_best_hop.sv
// Walks the neighbour table word by word and reports the best next hop
// and the best in-cluster cluster head.
module find_best_hop
  import find_best_hop_pkg::*;
(
  input  logic        clock,
  input  logic        nrst,
  input  logic        start,
  input  logic [15:0] my_cluster_id,
  output logic [15:0] address,
  input  logic [15:0] data_in,
  output logic [15:0] nexthop,
  output logic [15:0] nextsinks,
  output logic        done
);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] hop_q, hop_d;
  logic [15:0] sink_q, sink_d;
  logic        done_q, done_d;
  logic [6:0]  idx_q, idx_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [15:0] mycl_q, mycl_d;
  logic [15:0] id_q, id_d;
  logic [15:0] cl_q, cl_d;
  logic        ch_q, ch_d;

  logic        clr;
  logic        upd;
  logic        valid_id;
  logic        in_sink;
  logic [6:0]  clamped;
  logic [6:0]  idx_nx;
  logic [15:0] best_hop;
  logic [15:0] best_sink;

  assign clamped = (data_in > 16'(MAX_NBR))
                 ? 7'(MAX_NBR) : data_in[6:0];
  assign idx_nx   = idx_q + 7'd1;
  assign valid_id = (id_q != NONE_ID);
  assign in_sink  = valid_id && ch_q
                 && (cl_q == mycl_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hop_d   = hop_q;
    sink_d  = sink_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mycl_d  = mycl_q;
    id_d    = id_q;
    cl_d    = cl_q;
    ch_d    = ch_q;
    clr     = 1'b0;
    upd     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mycl_d  = my_cluster_id;
          clr     = 1'b1;
          state_d = S_CNT_REQ;
        end
      end
      S_CNT_REQ: begin
        addr_d  = CNT_ADDR;
        state_d = S_CNT_CAP;
      end
      S_CNT_CAP: begin
        cnt_d   = clamped;
        idx_d   = '0;
        state_d = (clamped == '0)
                ? S_DONE : S_ID_REQ;
      end
      S_ID_REQ: begin
        addr_d  = entry_addr(idx_q, OFF_ID);
        state_d = S_CL_REQ;
      end
      S_CL_REQ: begin
        id_d    = data_in;
        addr_d  = entry_addr(idx_q, OFF_CL);
        state_d = S_FL_REQ;
      end
      S_FL_REQ: begin
        cl_d    = data_in;
        addr_d  = entry_addr(idx_q, OFF_FL);
        state_d = S_Q_REQ;
      end
      S_Q_REQ: begin
        ch_d    = data_in[0];
        addr_d  = entry_addr(idx_q, OFF_Q);
        state_d = S_EVAL;
      end
      S_EVAL: begin
        upd = 1'b1;
        if (idx_nx == cnt_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_nx;
          state_d = S_ID_REQ;
        end
      end
      S_DONE: begin
        hop_d   = best_hop;
        sink_d  = best_sink;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      hop_q   <= NONE_ID;
      sink_q  <= NONE_ID;
      done_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      mycl_q  <= '0;
      id_q    <= '0;
      cl_q    <= '0;
      ch_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hop_q   <= hop_d;
      sink_q  <= sink_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mycl_q  <= mycl_d;
      id_q    <= id_d;
      cl_q    <= cl_d;
      ch_q    <= ch_d;
    end
  end

  best_tracker u_hop (
    .clock     (clock),
    .nrst      (nrst),
    .clear_i   (clr),
    .qualify_i (valid_id),
    .update_i  (upd),
    .id_i      (id_q),
    .q_i       (data_in),
    .id_o      (best_hop)
  );

  best_tracker u_sink (
    .clock     (clock),
    .nrst      (nrst),
    .clear_i   (clr),
    .qualify_i (in_sink),
    .update_i  (upd),
    .id_i      (id_q),
    .q_i       (data_in),
    .id_o      (best_sink)
  );

  assign address   = addr_q;
  assign nexthop   = hop_q;
  assign nextsinks = sink_q;
  assign done      = done_q;

endmodule

// File: tb/tb_find_best_hop.sv
// Scoreboard bench for find_best_hop: stimulus pushes expected results,
// a monitor pops them on every done pulse.
module tb_find_best_hop;

  logic        clock = 1'b0;
  logic        nrst;
  logic        start;
  logic [15:0] my_cluster_id;
  logic [15:0] address;
  logic [15:0] data_in;
  logic [15:0] nexthop;
  logic [15:0] nextsinks;
  logic        done;

  logic [7:0] mem [0:1023];

  typedef struct {
    logic [15:0] hop;
    logic [15:0] sink;
    int          done_cyc;
    bit          chk_tr;
    int          tlen;
    int unsigned thash;
  } exp_t;

  exp_t exp_q[$];

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          cyc    = 0;
  logic [15:0] tr_prev = 16'hFFFF;
  int          tr_len  = 0;
  int unsigned tr_hash = 0;

  find_best_hop dut (
    .clock         (clock),
    .nrst          (nrst),
    .start         (start),
    .my_cluster_id (my_cluster_id),
    .address       (address),
    .data_in       (data_in),
    .nexthop       (nexthop),
    .nextsinks     (nextsinks),
    .done          (done)
  );

  always #5 clock = ~clock;

  assign data_in = {mem[address[9:0]],
                    mem[10'(address[9:0] + 10'd1)]};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // address trace: consecutive distinct values
  initial forever begin
    @(negedge clock);
    if (address !== tr_prev) begin
      tr_prev = address;
      tr_len++;
      tr_hash = tr_hash * 31 + 32'(address);
    end
  end

  initial forever begin
    @(negedge clock);
    if (nrst === 1'b1 && done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("nexthop", 32'(nexthop), 32'(e.hop));
        chk("nextsinks", 32'(nextsinks), 32'(e.sink));
        chk("latency", 32'(cyc), 32'(e.done_cyc));
        if (e.chk_tr) begin
          chk("trace_len", 32'(tr_len), 32'(e.tlen));
          chk("trace_hash", tr_hash, e.thash);
        end
      end
    end
  end

  task automatic wr16(input int a, input int v);
    mem[a]     = 8'(v >> 8);
    mem[a + 1] = 8'(v);
  endtask

  task automatic wr_ent(input int i, input int id,
                        input int cl, input int fl,
                        input int q);
    int b;
    b = 32 + 8 * i;
    wr16(b, id);
    wr16(b + 2, cl);
    wr16(b + 4, fl);
    wr16(b + 6, q);
  endtask

  function automatic void exp_trace(input int n,
                                    output int len,
                                    output int unsigned h);
    h   = 32'h10;
    len = 1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        h = h * 31 + 32'(32 + 8 * i + 2 * k);
        len++;
      end
    end
  endfunction

  task automatic scan(input int cl, input int hop,
                      input int sink, input int n,
                      input bit push);
    exp_t e;
    @(negedge clock);
    my_cluster_id = 16'(cl);
    start = 1'b1;
    e.hop      = 16'(hop);
    e.sink     = 16'(sink);
    e.done_cyc = cyc + 1 + 3 + 5 * n;
    e.chk_tr   = 1'b1;
    exp_trace(n, e.tlen, e.thash);
    if (push) exp_q.push_back(e);
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    #1;
    tr_prev = 16'hFFFF;
    tr_len  = 0;
    tr_hash = 0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(negedge clock);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic load_t2();
    wr16(16, 3);
    wr_ent(0, 5, 1, 1, 100);
    wr_ent(1, 9, 1, 1, 300);
    wr_ent(2, 12, 1, 1, 200);
  endtask

  task automatic load_t3();
    wr16(16, 3);
    wr_ent(0, 7, 2, 1, 50);
    wr_ent(1, 8, 2, 0, 90);
    wr_ent(2, 11, 2, 1, 70);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    nrst = 1'b0;
    start = 1'b0;
    my_cluster_id = 16'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_nexthop", 32'(nexthop), 32'd65);
    chk("rst_nextsinks", 32'(nextsinks), 32'd65);
    chk("rst_done", 32'(done), 32'd0);
    nrst = 1'b1;

    // empty table
    wr16(16, 0);
    scan(4, 65, 65, 0, 1'b1);
    drain();

    load_t2();
    scan(7, 9, 65, 3, 1'b1);
    drain();

    load_t3();
    scan(2, 8, 11, 3, 1'b1);
    drain();

    // clamp 200 -> 64, ties, skipped sentinel, zero-Q sink
    wr16(16, 200);
    for (int i = 2; i < 64; i++) wr_ent(i, 100 + i, 9, 0, i);
    wr_ent(0, 3, 9, 0, 16'h0100);
    wr_ent(1, 4, 9, 0, 16'h0100);
    wr_ent(5, 65, 9, 1, 16'hFFFF);
    wr_ent(10, 110, 9, 1, 0);
    wr_ent(64, 77, 9, 1, 16'hFFFF);
    scan(9, 3, 110, 64, 1'b1);
    drain();

    // reset during EVAL of entry 1
    load_t3();
    scan(2, 8, 11, 3, 1'b0);
    repeat (10) @(posedge clock);
    #1 nrst = 1'b0;
    repeat (2) @(posedge clock);
    #1 nrst = 1'b1;
    @(negedge clock);
    chk("abort_nexthop", 32'(nexthop), 32'd65);
    chk("abort_nextsinks", 32'(nextsinks), 32'd65);
    chk("abort_address", 32'(address), 32'd0);
    repeat (40) @(negedge clock);
    scan(2, 8, 11, 3, 1'b1);
    drain();

    // start mid-scan and held through DONE
    load_t2();
    scan(7, 9, 65, 3, 1'b1);
    repeat (4) @(posedge clock);
    #1 start = 1'b1;
    repeat (2) @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    chk("hold_nexthop", 32'(nexthop), 32'd8);
    chk("hold_nextsinks", 32'(nextsinks), 32'd11);
    repeat (8) @(posedge clock);
    #1 start = 1'b1;
    repeat (3) @(posedge clock);
    #1 start = 1'b0;
    drain();
    repeat (30) @(negedge clock);
    chk("after_nexthop", 32'(nexthop), 32'd9);
    chk("done_count", 32'(n_done), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish",
             cyc);
    $fatal(1, "timeout");
  end

endmodule
